ray_column_scheduler: RTL
=========================

// Module: ray_column_scheduler
// PURPOSE
// Sequences one shared ray-march engine across all screen columns, replacing per-column combinational raycasting.
// On each frame_start it issues one ray per column, waits for the engine, and writes {colour,height} into a
// double-buffered column RAM. At frame end it swaps banks so the VGA pixel logic always reads a complete frame.
// PARAMETERS
// NUM_COLS   640   columns cast per frame (index 0..NUM_COLS-1)
// COL_W      10    width of column index
// HEIGHT_W   9     width of wall-slice height
// MAX_HEIGHT 480   heights above this are clamped to MAX_HEIGHT
// TIMEOUT    1023  max cycles in WAIT before a column is abandoned
// PORTS
// clk         in   1            system clock (50 MHz)
// rst         in   1            asynchronous, active-low reset
// frame_start in   1            1-cycle pulse at start of vertical blank
// ray_start   out  1            1-cycle pulse: engine begins ray for ray_col
// ray_col     out  COL_W        column being cast; stable from ISSUE until the next ISSUE
// ray_done    in   1            1-cycle pulse: engine result valid
// ray_height  in   HEIGHT_W     wall-slice height from engine
// ray_color   in   2            wall colour code from engine
// buf_we      out  1            column RAM write enable
// buf_waddr   out  COL_W        column RAM write address
// buf_wdata   out  HEIGHT_W+2   {colour[1:0], height}
// buf_bank    out  1            bank being written
// disp_bank   out  1            bank the display reads
// busy        out  1            high whenever state != IDLE
// frame_done  out  1            1-cycle pulse when banks swap
// overrun     out  1            1-cycle pulse: frame_start arrived while busy
// timeout_err out  1            sticky; set on any engine timeout, cleared only by reset
// BEHAVIOUR
// - Reset: state IDLE; col=0; all pulses, busy, buf_we, buf_waddr, buf_wdata, timeout_err = 0; buf_bank=0; disp_bank=1.
// - States: IDLE, ISSUE, WAIT, WRITE, NEXT, SWAP. All outputs are registered.
// - IDLE: frame_start -> ISSUE on the next edge, with col=0.
// - ISSUE (1 cycle): ray_start=1, ray_col=col, wait counter cleared; -> WAIT.
// - WAIT: on ray_done, latch min(ray_height,MAX_HEIGHT) and ray_color; -> WRITE.
//   If the counter reaches TIMEOUT without ray_done: latch height 0, colour 0, set timeout_err; -> WRITE.
//   If ray_done arrives on the same cycle as expiry, ray_done wins and timeout_err is not set.
// - WRITE (1 cycle): buf_we=1, buf_waddr=col, buf_wdata={colour,height}; -> NEXT.
// - NEXT: if col==NUM_COLS-1 -> SWAP; else col<=col+1 -> ISSUE. The column index never wraps mid-frame.
// - SWAP (1 cycle): disp_bank<=buf_bank, buf_bank<=~buf_bank, frame_done=1; -> IDLE.
// - Per-column cost: ISSUE + (engine latency) WAIT cycles + WRITE + NEXT, i.e. 3 cycles + engine latency.
// - frame_start outside IDLE: ignored; overrun pulses once per occurrence. The frame in progress completes undisturbed.
// - ray_done outside WAIT: ignored, no side effects.
// - Reset asserted mid-frame: immediate return to reset values. The partial bank is never shown because no swap occurs.
// - buf_bank != disp_bank at all times.
// TESTING
// 1 Reset, frame_start, engine with 2-cycle latency, height=col%480 -> 640 writes, addr 0..639 in order, frame_done once, banks 0/1 -> 1/0.
// 2 ray_height=500, colour=3 -> buf_wdata={2'd3,9'd480}; ray_height=480 -> written unchanged.
// 3 Engine silent on col 5 -> after 1023 WAIT cycles, addr 5 written 0 and timeout_err=1; cols 6..639 proceed normally.
// 4 frame_start pulsed during col 100 -> overrun=1 for 1 cycle, single frame_done, no restart at col 0.
// 5 rst low during col 300 -> all outputs at reset values next cycle, disp_bank=1, no frame_done; a later frame_start restarts at col 0.
// 6 ray_done on exact timeout cycle -> engine data written, timeout_err stays 0.

Source files
------------

// File: rtl/ray_column_scheduler_if.sv
// Bus between the column scheduler, its frame trigger, the shared ray-march
// engine and the double-buffered column RAM.
interface ray_column_scheduler_if #(
  parameter int COL_W    = 10,
  parameter int HEIGHT_W = 9
);
  logic                  frame_start;
  logic                  ray_start;
  logic [COL_W-1:0]      ray_col;
  logic                  ray_done;
  logic [HEIGHT_W-1:0]   ray_height;
  logic [1:0]            ray_color;
  logic                  buf_we;
  logic [COL_W-1:0]      buf_waddr;
  logic [HEIGHT_W+1:0]   buf_wdata;
  logic                  buf_bank;
  logic                  disp_bank;
  logic                  busy;
  logic                  frame_done;
  logic                  overrun;
  logic                  timeout_err;

  // Scheduler side.
  modport slave (
    input  frame_start, ray_done, ray_height, ray_color,
    output ray_start, ray_col, buf_we, buf_waddr, buf_wdata,
           buf_bank, disp_bank, busy, frame_done, overrun, timeout_err
  );

  // Environment side: frame trigger, engine and RAM/display.
  modport master (
    output frame_start, ray_done, ray_height, ray_color,
    input  ray_start, ray_col, buf_we, buf_waddr, buf_wdata,
           buf_bank, disp_bank, busy, frame_done, overrun, timeout_err
  );
endinterface

// File: rtl/ray_column_scheduler.sv
// Time-shares one ray-march engine across all screen columns. Each frame
// casts one ray per column, writes {colour,height} into the back bank of a
// double-buffered column RAM and swaps banks once the last column is stored,
// so the display only ever reads a complete frame.
module ray_column_scheduler #(
  parameter int NUM_COLS   = 640,
  parameter int COL_W      = 10,
  parameter int HEIGHT_W   = 9,
  parameter int MAX_HEIGHT = 480,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  ray_column_scheduler_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [HEIGHT_W-1:0] MAX_H    = HEIGHT_W'(MAX_HEIGHT);
  // Counter value seen on the last WAIT cycle before the column is abandoned.
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    SWAP  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ray_start_q, ray_start_d;
  logic [COL_W-1:0]      ray_col_q, ray_col_d;
  logic                  buf_we_q, buf_we_d;
  logic [COL_W-1:0]      buf_waddr_q, buf_waddr_d;
  logic [HEIGHT_W+1:0]   buf_wdata_q, buf_wdata_d;
  logic                  buf_bank_q, buf_bank_d;
  logic                  disp_bank_q, disp_bank_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_err_q, timeout_err_d;

  // Engine heights beyond the screen are clamped to the full-screen slice.
  function automatic logic [HEIGHT_W-1:0] clamp_height(input logic [HEIGHT_W-1:0] h);
    if (h > MAX_H) begin
      return MAX_H;
    end else begin
      return h;
    end
  endfunction

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that it is registered while the matching state is current.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    ray_col_d     = ray_col_q;
    buf_waddr_d   = buf_waddr_q;
    buf_wdata_d   = buf_wdata_q;
    buf_bank_d    = buf_bank_q;
    disp_bank_d   = disp_bank_q;
    timeout_err_d = timeout_err_q;
    ray_start_d   = 1'b0;
    buf_we_d      = 1'b0;
    frame_done_d  = 1'b0;
    overrun_d     = bus.frame_start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d     = ISSUE;
          col_d       = '0;
          ray_col_d   = '0;
          ray_start_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ray_done) begin
          // A result on the expiry cycle still counts as a normal completion.
          buf_wdata_d = {bus.ray_color, clamp_height(bus.ray_height)};
          buf_waddr_d = col_q;
          buf_we_d    = 1'b1;
          state_d     = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          buf_wdata_d   = '0;
          buf_waddr_d   = col_q;
          buf_we_d      = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        state_d = NEXT;
      end
      NEXT: begin
        if (col_q == LAST_COL) begin
          state_d      = SWAP;
          frame_done_d = 1'b1;
          disp_bank_d  = buf_bank_q;
          buf_bank_d   = ~buf_bank_q;
        end else begin
          col_d       = col_q + COL_W'(1);
          ray_col_d   = col_q + COL_W'(1);
          ray_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      SWAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset leaves the display on bank 1 so the
  // first frame is built in bank 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      cnt_q         <= '0;
      ray_start_q   <= 1'b0;
      ray_col_q     <= '0;
      buf_we_q      <= 1'b0;
      buf_waddr_q   <= '0;
      buf_wdata_q   <= '0;
      buf_bank_q    <= 1'b0;
      disp_bank_q   <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      ray_start_q   <= ray_start_d;
      ray_col_q     <= ray_col_d;
      buf_we_q      <= buf_we_d;
      buf_waddr_q   <= buf_waddr_d;
      buf_wdata_q   <= buf_wdata_d;
      buf_bank_q    <= buf_bank_d;
      disp_bank_q   <= disp_bank_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.ray_start   = ray_start_q;
  assign bus.ray_col     = ray_col_q;
  assign bus.buf_we      = buf_we_q;
  assign bus.buf_waddr   = buf_waddr_q;
  assign bus.buf_wdata   = buf_wdata_q;
  assign bus.buf_bank    = buf_bank_q;
  assign bus.disp_bank   = disp_bank_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
